// File: rtl/cpu_run_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_run_pkg : shared types for the CPU run sequencer                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_WARMUP  = 3'd2,
    S_RUN     = 3'd3,
    S_RUNDOWN = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_HALT    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ABORT   = 2'd3
  } status_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_phase_timer : loadable down-counter, Expire when count is zero   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cpu_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_run_sequencer : reset / warm-up / run / rundown control of core  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpu_run_sequencer
  import cpu_run_pkg::*;
#(
  parameter int unsigned RSTCYCLES = 4,
  parameter int unsigned WARMUP    = 3,
  parameter int unsigned RUNDOWN   = 8,
  parameter int unsigned CNTW      = 32,
  parameter int unsigned WCW       = 16
) (
  input  logic            clk,
  input  logic            sync_rst,
  input  logic            Start,
  input  logic            Abort,
  input  logic [CNTW-1:0] CycleLimit,
  input  logic            HaltIn,
  input  logic            RegWriteEn,
  output logic            CoreSyncRst,
  output logic            CoreClkEn,
  output logic            CoreSystemEn,
  output logic            Busy,
  output logic            Done,
  output logic [1:0]      Status,
  output logic [CNTW-1:0] RunCycles,
  output logic [WCW-1:0]  WriteCount
);

  localparam int unsigned c_TW = $clog2(max3(RSTCYCLES, WARMUP, RUNDOWN) + 1);
  // Timer counts N-1 down to 0 so that a phase lasts exactly N cycles.
  localparam logic [c_TW-1:0] c_RST_LOAD  = c_TW'(RSTCYCLES - 1);
  localparam logic [c_TW-1:0] c_WARM_LOAD = c_TW'(WARMUP - 1);
  localparam logic [c_TW-1:0] c_RD_LOAD   = c_TW'(RUNDOWN - 1);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [CNTW-1:0]   limit_q;
  logic [CNTW-1:0]   run_cycles_q;
  logic [WCW-1:0]    write_count_q;
  logic              core_rst_q, clk_en_q, sys_en_q, busy_q, done_q;
  logic              start_acc;
  logic              tmr_load;
  logic [c_TW-1:0]   tmr_val;
  logic              tmr_expire;

  seq_phase_timer #(
    .W (c_TW)
  ) u_phase_timer (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (busy_q),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    start_acc = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          state_d   = S_RESET;
          status_d  = ST_NONE;
          start_acc = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = c_RST_LOAD;
        end
      end
      S_RESET: begin
        if (Abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (tmr_expire) begin
          state_d  = S_WARMUP;
          tmr_load = 1'b1;
          tmr_val  = c_WARM_LOAD;
        end
      end
      S_WARMUP: begin
        if (Abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (tmr_expire) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The count including this cycle is compared, so the exit cycle is counted.
        if (Abort || HaltIn ||
            ((limit_q != '0) && ((run_cycles_q + CNTW'(1)) == limit_q))) begin
          state_d  = S_RUNDOWN;
          tmr_load = 1'b1;
          tmr_val  = c_RD_LOAD;
          if (Abort) begin
            status_d = ST_ABORT;
          end else if (HaltIn) begin
            status_d = ST_HALT;
          end else begin
            status_d = ST_TIMEOUT;
          end
        end
      end
      S_RUNDOWN: begin
        if (tmr_expire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q       <= S_IDLE;
      status_q      <= ST_NONE;
      limit_q       <= '0;
      run_cycles_q  <= '0;
      write_count_q <= '0;
      core_rst_q    <= 1'b0;
      clk_en_q      <= 1'b0;
      sys_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      core_rst_q <= (state_d == S_RESET);
      clk_en_q   <= (state_d == S_RESET) || (state_d == S_WARMUP) ||
                    (state_d == S_RUN)   || (state_d == S_RUNDOWN);
      sys_en_q   <= (state_d == S_RUN);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      if (start_acc) begin
        limit_q       <= CycleLimit;
        run_cycles_q  <= '0;
        write_count_q <= '0;
      end else begin
        if ((state_q == S_RUN) && !(&run_cycles_q)) begin
          run_cycles_q <= run_cycles_q + CNTW'(1);
        end
        if (((state_q == S_RUN) || (state_q == S_RUNDOWN)) && RegWriteEn &&
            !(&write_count_q)) begin
          write_count_q <= write_count_q + WCW'(1);
        end
      end
    end
  end

  assign CoreSyncRst  = core_rst_q;
  assign CoreClkEn    = clk_en_q;
  assign CoreSystemEn = sys_en_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Status       = status_q;
  assign RunCycles    = run_cycles_q;
  assign WriteCount   = write_count_q;

endmodule
`default_nettype wire

// File: doc/cpu_run_sequencer.md
# cpu_run_sequencer

Synthesizable run controller for the CPU core: sequences reset, clock enable and system enable on a start request, monitors halt, enforces a cycle limit, then drains for a fixed rundown window before reporting completion. Sits between a host/debug interface and the core's control inputs (core sync reset, clk_en, SystemEn, HaltOut, register write strobe). Replaces hand-timed enable sequencing with one deterministic FSM.

## Interface
- RSTCYCLES, 4: cycles CoreSyncRst is held (≥1)
- WARMUP, 3: cycles of clk_en before SystemEn rises (≥1)
- RUNDOWN, 8: drain cycles after run ends (≥1)
- CNTW, 32: width of CycleLimit / RunCycles
- WCW, 16: width of WriteCount

- clk  in  1  system clock; all logic on posedge
- sync_rst  in  1  synchronous, active-high reset of this block
- Start  in  1  begin run; sampled only in IDLE
- Abort  in  1  terminate run; level, sampled every cycle
- CycleLimit  in  CNTW  max RUN cycles; 0 = unlimited; latched at Start
- HaltIn  in  1  core HaltOut
- RegWriteEn  in  1  core RegisterWriteEn_OUT
- CoreSyncRst  out  1  core synchronous reset
- CoreClkEn  out  1  core clk_en
- CoreSystemEn  out  1  core SystemEn
- Busy  out  1  state ≠ IDLE
- Done  out  1  one-cycle pulse in DONE
- Status  out  2  0 NONE, 1 HALT, 2 TIMEOUT, 3 ABORT; held until next accepted Start
- RunCycles  out  CNTW  cycles spent in RUN, saturating
- WriteCount  out  WCW  RegWriteEn cycles counted in RUN and RUNDOWN, saturating

## Operation
- States: IDLE → RESET → WARMUP → RUN → RUNDOWN → DONE → IDLE.
- IDLE: all core outputs 0. Start && !Abort → RESET; load phase timer RSTCYCLES; clear RunCycles, WriteCount, Status; latch CycleLimit.
- RESET: CoreSyncRst=1, CoreClkEn=1, CoreSystemEn=0 for RSTCYCLES cycles → WARMUP.
- WARMUP: CoreClkEn=1 only, for WARMUP cycles → RUN.
- RUN: CoreClkEn=1, CoreSystemEn=1; RunCycles increments each cycle. Exit conditions evaluated each cycle, priority Abort > HaltIn > limit: Abort → RUNDOWN, Status=ABORT; HaltIn → RUNDOWN, Status=HALT; CycleLimit≠0 and RunCycles+1 == CycleLimit → RUNDOWN, Status=TIMEOUT. RunCycles counts the exit cycle.
- RUNDOWN: CoreClkEn=1, CoreSystemEn=0, for RUNDOWN cycles; Abort here ignored (drain completes) → DONE.
- Abort in RESET or WARMUP → DONE directly, Status=ABORT, core outputs drop next cycle.
- DONE: core outputs 0, Done=1 for one cycle → IDLE.
- Start outside IDLE ignored. HaltIn outside RUN ignored.
- Saturation: RunCycles and WriteCount hold at all-ones, never wrap.
- sync_rst at any time: next state IDLE, all outputs 0, Status NONE, counters 0; an in-flight run is dropped without Done.

## Timing
- All outputs registered; reset value 0 for every output.
- Start sampled at edge T → Busy, CoreSyncRst, CoreClkEn high from T+1; CoreSyncRst high exactly RSTCYCLES cycles (T+1..T+RSTCYCLES).
- CoreSystemEn rises at T+1+RSTCYCLES+WARMUP.
- HaltIn high at edge H in RUN → CoreSystemEn low from H+1; CoreClkEn stays high through H+RUNDOWN; Done pulses at H+RUNDOWN+1; Busy low from H+RUNDOWN+2.
- CycleLimit=L: CoreSystemEn high exactly L cycles.
- Start may be re-accepted the cycle Busy is low.

## Structure
- Package cpu_run_pkg: state enum (IDLE, RESET, WARMUP, RUN, RUNDOWN, DONE), Status codes (ST_NONE/HALT/TIMEOUT/ABORT).
- One sub-module: seq_phase_timer — loadable down-counter with clk_en, load value, and Expire flag; shared by RESET, WARMUP, RUNDOWN phases (width $clog2 of max phase + 1).
- Saturating counters and FSM inline in top.

## Test plan
- Defaults, Start pulse at cycle 10, HaltIn at RUN cycle 5 → CoreSyncRst cycles 11–14, SystemEn 18–22, Done at 31, Status=1, RunCycles=5.
- CycleLimit=7, no halt → SystemEn high exactly 7 cycles, Status=2, RunCycles=7.
- Abort during WARMUP → SystemEn never rises, Done next cycle, Status=3, RunCycles=0.
- RegWriteEn high 3 cycles in RUN and 2 in RUNDOWN, 1 in IDLE → WriteCount=5.
- HaltIn and Abort same RUN cycle → Status=3; Start asserted while Busy → no restart, counters unchanged.
- sync_rst mid-RUN → next cycle all outputs 0, no Done pulse; fresh Start sequences normally.
